vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the VGA pixel path and a CPU bus port.
- Prefetches pixels, in address order, into a show-ahead FIFO that the VGA timing logic pops.
- Grants the RAM to the CPU whenever the FIFO is above its low watermark.
- Sits between the framebuffer RAM, the VGA controller and the RV core's memory-mapped bus.

Parameters:
- ADDR_W, 13, framebuffer address width
- DATA_W, 24, pixel/word width (RGB888)
- FRAME_PIXELS, 4800, pixels fetched per frame; addresses 0..FRAME_PIXELS-1
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2)
- LOW_WM, 2, refill-urgency threshold in entries

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse; flush FIFO, restart fetch at address 0
- pix_pop  in  1  consume FIFO head this cycle
- pix_valid  out  1  FIFO not empty
- pix_data  out  DATA_W  FIFO head; 0 when empty
- underflow  out  1  sticky: pop seen while empty; cleared by frame_start
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, registered, held until next read ack
- cpu_ack  out  1  one-cycle completion pulse
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read issue
- underflow_cnt  out  16  underflow event count (see Optional Feature)

Behaviour:
- Reset (async): all outputs 0; FIFO empty; fetch pointer 0; fetch enabled; FSM ARB; in-flight flag clear.
- RAM timing: mem_* outputs combinational from the grant. A read issued at cycle t returns mem_rdata at t+1.
- Grant per cycle, at most one RAM access. Define occ = fifo_count + in-flight pixel reads, and room = occ < FIFO_DEPTH and fetch pointer < FRAME_PIXELS.
  1. Pixel read if room and occ < LOW_WM (urgent).
  2. Otherwise CPU access if FSM = ARB and cpu_req = 1.
  3. Otherwise pixel read if room.
  4. Otherwise idle.
- Pixel read: mem_addr = fetch pointer; pointer += 1. Returned data is pushed at t+1 unless flushed.
- Fetch stops once the pointer reaches FRAME_PIXELS and resumes only after frame_start.
- CPU FSM:
  - ARB -> ISSUED when a CPU access is granted (cycle t).
  - ISSUED -> ACK at t+1; cpu_rdata captures mem_rdata on reads.
  - ACK (cpu_ack = 1 at t+2) -> ARB. cpu_req is ignored during the ACK cycle.
  - Reads and writes both complete at fixed t+2 latency.
  - Pixel reads may issue during ISSUED and ACK.
- FIFO: show-ahead. Pop when pix_pop and pix_valid. Push and pop in the same cycle leaves the count unchanged. A push is never lost, because occ bounds issue.
- Pop on empty: no state change, pix_data = 0, underflow set.
- frame_start:
  - FIFO count 0, pointer 0, underflow cleared.
  - Any in-flight pixel return on the next cycle is discarded.
  - Overrides pix_pop in the same cycle.
  - The CPU FSM is unaffected.
  - A pixel fetch may issue in the same cycle as frame_start; it uses address 0 and pointer ends at 1.
- Reset mid-transaction: the CPU access is abandoned with no ack; the master reissues.
- CPU starvation is permitted while the FIFO sits below LOW_WM. During blanking the FIFO fills, then the CPU gets every slot.

Optional Feature:
- VGA_FB_UFCNT_EN defined: underflow_cnt increments on each pop-while-empty and saturates at 16'hFFFF. It is cleared by rst only, not by frame_start.
- VGA_FB_UFCNT_EN undefined: underflow_cnt tied to 0 and no counter logic is built.

Test Plan:
- Reset, then frame_start with no pops and RAM preloaded mem[i]=i: 8 reads at addresses 0..7, fifo_count 8, pix_data 0, fetch idles with pointer 8.
- With the FIFO full, CPU write addr 100, data 24'hABCDEF issued at cycle t: mem_we=1, mem_addr=100 at t; cpu_ack at t+2. A later CPU read of 100 returns 24'hABCDEF with ack at t'+2.
- Pop every cycle with FIFO at 1 and a CPU read pending: the pixel read wins every cycle occ < 2. The CPU is granted the first cycle occ >= 2 and acks 2 cycles later.
- Pop 9 times after a fill with fetch stopped at the end of frame (FRAME_PIXELS=8): the 9th pop gives pix_data 0, underflow=1, and underflow_cnt=1 when the macro is defined.
- frame_start in the cycle after a pixel read issue at address 5: the returned data is not pushed, FIFO is empty, and the next fetch address is 0 (or 1 if a fetch issued alongside frame_start).
- Assert rst during CPU ISSUED: cpu_ack stays 0, all outputs 0 immediately, FSM returns to ARB.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// CPU-side memory-mapped bus for the framebuffer arbiter.
// master: the RV core bus port; slave: the arbiter.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port synchronous RAM between
// the VGA pixel prefetch FIFO and the CPU bus. Pixel fetch wins whenever
// the FIFO (plus reads in flight) is below the low watermark; otherwise the
// CPU gets the slot, and spare slots keep topping up the FIFO.
// Optional build macro: VGA_FB_UFCNT_EN enables the saturating underflow
// event counter on underflow_cnt_o (tied to 0 otherwise).
//
// CPU FSM
//   state  | meaning
//   ARB    | idle, CPU request may be granted this cycle
//   ISSUED | RAM access issued last cycle, read data on mem_rdata_i now
//   ACK    | cpu_ack pulse; request ignored this cycle
module vga_fb_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 24,
    parameter int FRAME_PIXELS = 4800,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_WM       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic              pix_pop_i,
    output logic              pix_valid_o,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              underflow_o,
    vga_fb_arbiter_if.slave   cpu,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       underflow_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_PIXELS);

    typedef enum logic [1:0] {ARB, ISSUED, ACK} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W:0]    fetch_ptr_q;
    logic               inflight_q;
    logic               underflow_q;
    logic               cpu_rd_q;
    logic [DATA_W-1:0]  cpu_rdata_q;

    logic [CNT_W-1:0]   count_eff, occ;
    logic [ADDR_W:0]    ptr_eff;
    logic               room, urgent, grant_cpu, grant_pix;
    logic               push, pop, uf_event;

    // frame_start restarts the frame in the same cycle, so the grant sees an
    // empty FIFO and pointer 0; a read in flight from before is ignored.
    always_comb begin
        count_eff = frame_start_i ? '0 : count_q;
        ptr_eff   = frame_start_i ? '0 : fetch_ptr_q;
        occ       = count_eff + CNT_W'(inflight_q && !frame_start_i);
        room      = (occ < CNT_W'(FIFO_DEPTH)) && (ptr_eff < FRAME_END);
        urgent    = room && (occ < CNT_W'(LOW_WM));
        grant_cpu = !urgent && (state_q == ARB) && cpu.cpu_req;
        grant_pix = room && !grant_cpu;
        push      = inflight_q && !frame_start_i;
        pop       = pix_pop_i && (count_q != '0) && !frame_start_i;
        uf_event  = pix_pop_i && (count_q == '0) && !frame_start_i;
    end

    // RAM port driven straight from the grant; forced quiet while in reset.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst) begin
            if (grant_cpu) begin
                mem_en_o   = 1'b1;
                mem_we_o   = cpu.cpu_we;
                mem_addr_o = cpu.cpu_addr;
                if (cpu.cpu_we) mem_wdata_o = cpu.cpu_wdata;
            end else if (grant_pix) begin
                mem_en_o   = 1'b1;
                mem_addr_o = ptr_eff[ADDR_W-1:0];
            end
        end
    end

    // Fetch pointer, in-flight flag and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fetch_ptr_q <= '0;
            inflight_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            inflight_q  <= grant_pix;
            fetch_ptr_q <= grant_pix ? ptr_eff + (ADDR_W+1)'(1) : ptr_eff;
            if (frame_start_i) begin
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                count_q     <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
                if (uf_event) underflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rdata_i;
    end

    assign pix_valid_o = (count_q != '0);
    assign pix_data_o  = pix_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign underflow_o = underflow_q;

    // CPU FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB;
        else     state_q <= state_d;
    end

    // CPU FSM next state: fixed two-cycle completion after the grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (grant_cpu) state_d = ISSUED;
            ISSUED:  state_d = ACK;
            ACK:     state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Remember the access direction and capture read data one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            if (grant_cpu) cpu_rd_q <= !cpu.cpu_we;
            if (state_q == ISSUED && cpu_rd_q) cpu_rdata_q <= mem_rdata_i;
        end
    end

    assign cpu.cpu_ack   = (state_q == ACK);
    assign cpu.cpu_rdata = cpu_rdata_q;

`ifdef VGA_FB_UFCNT_EN
    logic [15:0] uf_cnt_q;

    // Saturating count of pops while empty; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                uf_cnt_q <= '0;
        else if (uf_event && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
    end

    assign underflow_cnt_o = uf_cnt_q;
`else
    assign underflow_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a small frame so fetch end,
// underflow and frame restarts are reached often.
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 24;
    localparam int NPIX   = 16;
    localparam int DEPTH  = 8;
    localparam int LWM    = 2;
    localparam int MEMSZ  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_pop = 1'b0;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              underflow;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       underflow_cnt;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(NPIX),
        .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_start_i(frame_start), .pix_pop_i(pix_pop),
        .pix_valid_o(pix_valid), .pix_data_o(pix_data), .underflow_o(underflow),
        .cpu(cpu_if),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .underflow_cnt_o(underflow_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] pix_f(input int a);
        int v;
        v = a * 66051 + 42435;
        return v[DATA_W-1:0];
    endfunction

    // Synchronous single-port RAM, initial contents pix_f(addr).
    logic [DATA_W-1:0] ram_d [0:MEMSZ-1];
    bit                ram_w [0:MEMSZ-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram_d[mem_addr] <= mem_wdata;
                ram_w[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_w[mem_addr] ? ram_d[mem_addr] : pix_f(int'(mem_addr));
            end
        end
    end

    // Reference shadow of memory contents as seen by the CPU.
    logic [DATA_W-1:0] sh_d [0:MEMSZ-1];
    bit                sh_w [0:MEMSZ-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cpu_txn_t;

    // Reference model state.
    cpu_txn_t          cpu_q[$];
    int                ready_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                fetched;
    logic              uf_exp;
    int                ufcnt_exp;
    bit                granted;
    int                grant_cyc;

    function automatic void frame_restart();
        ready_q.delete();
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(pix_f(i));
        fetched = 0;
    endfunction

    int       occ, kind_exp, kind_obs;
    bit       room, pending, valid_exp, ack_exp;
    cpu_txn_t txn;

    // Monitor: evaluates each cycle's outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_cpu_ack", cpu_if.cpu_ack, 0);
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_pix_data", pix_data, 0);
            chk("rst_underflow", underflow, 0);
            chk("rst_cpu_rdata", cpu_if.cpu_rdata, 0);
            chk("rst_ufcnt", underflow_cnt, 0);
            frame_restart();
            uf_exp = 1'b0;
            ufcnt_exp = 0;
            granted = 1'b0;
            cpu_q.delete();
        end else begin
            valid_exp = (ready_q.size() > 0) && (ready_q[0] <= cyc);
            chk("pix_valid", pix_valid, valid_exp);
            if (!valid_exp) chk("pix_data_empty", pix_data, 0);
            chk("underflow", underflow, uf_exp);
`ifdef VGA_FB_UFCNT_EN
            chk("ufcnt", underflow_cnt, ufcnt_exp);
`else
            chk("ufcnt", underflow_cnt, 0);
`endif
            pending = cpu_if.cpu_req && !granted && (cpu_q.size() > 0);
            ack_exp = granted && (cyc == grant_cyc + 2);
            chk("cpu_ack", cpu_if.cpu_ack, ack_exp);
            if (ack_exp) begin
                if (cpu_q.size() > 0) begin
                    txn = cpu_q.pop_front();
                    if (!txn.we) chk("cpu_rdata", cpu_if.cpu_rdata, txn.data);
                end
                granted = 1'b0;
            end

            if (frame_start) begin
                frame_restart();
                uf_exp = 1'b0;
            end
            occ  = ready_q.size();
            room = (occ < DEPTH) && (fetched < NPIX);
            if (room && occ < LWM) kind_exp = 1;
            else if (pending)      kind_exp = 2;
            else if (room)         kind_exp = 1;
            else                   kind_exp = 0;
            if (!mem_en)                             kind_obs = 0;
            else if (mem_we || int'(mem_addr) >= NPIX) kind_obs = 2;
            else                                     kind_obs = 1;
            chk("grant_kind", kind_obs, kind_exp);

            if (!frame_start && pix_pop) begin
                if (valid_exp) begin
                    chk("pix_data", pix_data, exp_q.pop_front());
                    void'(ready_q.pop_front());
                end else begin
                    uf_exp = 1'b1;
                    if (ufcnt_exp < 65535) ufcnt_exp++;
                end
            end

            if (kind_obs == 1) begin
                chk("pix_addr", mem_addr, fetched);
                ready_q.push_back(cyc + 2);
                fetched++;
            end
            if (kind_obs == 2 && cpu_q.size() > 0) begin
                chk("cpu_mem_addr", mem_addr, cpu_q[0].addr);
                chk("cpu_mem_we", mem_we, cpu_q[0].we);
                if (cpu_q[0].we) chk("cpu_mem_wdata", mem_wdata, cpu_q[0].data);
                granted   = 1'b1;
                grant_cyc = cyc;
            end
        end
    end

    // Issue one CPU access and wait (bounded) for its ack.
    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
        cpu_txn_t t;
        int n;
        t.we   = we;
        t.addr = addr;
        t.data = we ? data : (sh_w[addr] ? sh_d[addr] : pix_f(int'(addr)));
        if (we) begin
            sh_d[addr] = data;
            sh_w[addr] = 1'b1;
        end
        cpu_q.push_back(t);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = addr;
        cpu_if.cpu_wdata = we ? data : DATA_W'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_if.cpu_ack && n < 400);
        if (!cpu_if.cpu_ack) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: no ack for addr %0h after %0d cycles", addr, n);
            cpu_q.delete();
            granted = 1'b0;
        end
        @(posedge clk);
        #1;
        cpu_if.cpu_req = 1'b0;
    endtask

    task automatic run_pix(input int ncyc, input int pop_pct, input int fs_pm);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            pix_pop     = ($urandom_range(99) < pop_pct);
            frame_start = ($urandom_range(999) < fs_pm);
        end
        @(posedge clk);
        #1;
        pix_pop     = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill after reset with no pops, then CPU write/read round trip.
        run_pix(20, 0, 0);
        cpu_access(1'b1, 13'd100, 24'hABCDEF);
        cpu_access(1'b0, 13'd100, 24'h0);

        // Pop every cycle from a fresh frame while a CPU read waits.
        fork
            begin
                run_pix(1, 100, 1000);
                run_pix(14, 100, 0);
            end
            cpu_access(1'b0, 13'd200, 24'h0);
        join

        // Drain past the end of frame to provoke underflow, then restart.
        run_pix(30, 100, 0);
        run_pix(3, 0, 0);
        run_pix(1, 0, 1000);

        // frame_start the cycle after the fetch of address 5.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (fetched != 6 && n < 50);
        if (fetched != 6) begin
            checks++;
            errors++;
            $display("FAIL wait_fetch5: fetch count %0d required 6", fetched);
        end
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        run_pix(20, 0, 0);
        run_pix(10, 50, 0);

        // Random traffic.
        fork
            run_pix(3000, 60, 30);
            begin
                repeat (60) begin
                    repeat ($urandom_range(20)) @(posedge clk);
                    #1;
                    cpu_access(1'($urandom_range(1)), ADDR_W'(16 + $urandom_range(31)),
                               DATA_W'($urandom));
                end
            end
        join

        // Reset while a CPU read is in the ISSUED cycle.
        run_pix(20, 0, 0);
        txn.we   = 1'b0;
        txn.addr = 13'd300;
        txn.data = pix_f(300);
        cpu_q.push_back(txn);
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_we   = 1'b0;
        cpu_if.cpu_addr = 13'd300;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!granted && n < 50);
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: CPU read of 300 not granted in %0d cycles", n);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_now_mem_en", mem_en, 0);
        chk("rst_now_mem_addr", mem_addr, 0);
        chk("rst_now_cpu_ack", cpu_if.cpu_ack, 0);
        chk("rst_now_pix_valid", pix_valid, 0);
        chk("rst_now_cpu_rdata", cpu_if.cpu_rdata, 0);
        cpu_if.cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_access(1'b0, 13'd300, 24'h0);
        run_pix(40, 50, 0);
        cpu_access(1'b0, 13'd100, 24'h0);
        run_pix(5, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
